// File: rtl/noc_alloc_pkg.sv
// rtl/noc_alloc_pkg.sv - shared types and helpers for the router output allocators
// Contents:
//   alloc_state_t  : allocator ownership state (IDLE / LOCKED)
//   MAX_INPUTS     : widest request vector onehot_to_idx accepts
//   credit_width   : width of a counter that must hold 0..depth
//   onehot_to_idx  : index of the set bit of a one-hot vector (0 when none set)
package noc_alloc_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } alloc_state_t;

  localparam int MAX_INPUTS = 32;

  function automatic int credit_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int onehot_to_idx(input logic [MAX_INPUTS-1:0] oh);
    int idx;
    idx = 0;
    for (int i = 0; i < MAX_INPUTS; i++) begin
      if (oh[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/wormhole_output_allocator_if.sv
// rtl/wormhole_output_allocator_if.sv - request/grant/credit bundle of one router output
// Signals:
//   req_in, is_tail_in : per-input head-flit request and tail marker (driver -> allocator)
//   credit_in          : downstream freed one slot (driver -> allocator)
//   grant_out          : one-hot crossbar select (allocator -> driver)
//   send_out           : flit moves this cycle (allocator -> driver)
//   locked_out         : a packet owns the output
//   credits_out        : downstream credit count
//   credit_err_out     : sticky credit overflow flag
// Modports: master = router side driving requests, slave = allocator.
interface wormhole_output_allocator_if #(
  parameter int NUM_INPUTS   = 2,
  parameter int CREDIT_WIDTH = 3
);

  logic [NUM_INPUTS-1:0]   req_in;
  logic [NUM_INPUTS-1:0]   is_tail_in;
  logic                    credit_in;
  logic [NUM_INPUTS-1:0]   grant_out;
  logic                    send_out;
  logic                    locked_out;
  logic [CREDIT_WIDTH-1:0] credits_out;
  logic                    credit_err_out;

  modport master (
    output req_in, is_tail_in, credit_in,
    input  grant_out, send_out, locked_out, credits_out, credit_err_out
  );

  modport slave (
    input  req_in, is_tail_in, credit_in,
    output grant_out, send_out, locked_out, credits_out, credit_err_out
  );

endinterface

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick starting at a base pointer
// Ports:
//   req   [N]  : request vector
//   base  [IW] : highest-priority index this cycle
//   grant [N]  : one-hot grant, zero when no request
//   idx   [IW] : index of the granted request (0 when none)
module rr_arbiter
  import noc_alloc_pkg::*;
#(
  parameter int N  = 2,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] base,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx
);

  logic [MAX_INPUTS-1:0] wide;
  logic                  found;

  // Two ascending passes: indices at or above base first, then the wrapped
  // ones below base. This is the modulo-N scan without a variable index.
  always_comb begin
    grant = '0;
    found = 1'b0;
    for (int j = 0; j < N; j++) begin
      if (!found && req[j] && (j >= int'(base))) begin
        grant[j] = 1'b1;
        found    = 1'b1;
      end
    end
    for (int j = 0; j < N; j++) begin
      if (!found && req[j] && (j < int'(base))) begin
        grant[j] = 1'b1;
        found    = 1'b1;
      end
    end
    wide        = '0;
    wide[N-1:0] = grant;
    idx         = IW'(onehot_to_idx(wide));
  end

endmodule

// File: rtl/wormhole_output_allocator.sv
// rtl/wormhole_output_allocator.sv - per-output wormhole switch allocator with credit gating
// Ports:
//   clk : clock
//   rst : synchronous active-high reset
//   bus : slave side of wormhole_output_allocator_if (requests, tails, credit
//         return in; grant, send, lock, credit count and credit error out)
// A packet keeps the output from its head until its tail has been sent; the
// first flit moves in the same cycle it is granted.
module wormhole_output_allocator
  import noc_alloc_pkg::*;
#(
  parameter int NUM_INPUTS        = 2,
  parameter int FLIT_BUFFER_DEPTH = 4,
  parameter int CREDIT_WIDTH      = credit_width(FLIT_BUFFER_DEPTH)
) (
  input logic                        clk,
  input logic                        rst,
  wormhole_output_allocator_if.slave bus
);

  localparam int IDX_W = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
  localparam logic [CREDIT_WIDTH-1:0] FULL = CREDIT_WIDTH'(FLIT_BUFFER_DEPTH);

  alloc_state_t            state_q, state_d;
  logic [IDX_W-1:0]        owner_q, owner_d;
  logic [IDX_W-1:0]        rr_ptr_q, rr_ptr_d;
  logic [CREDIT_WIDTH-1:0] credits_q, credits_d;
  logic                    err_q, err_d;

  logic [NUM_INPUTS-1:0]   arb_grant, owner_oh, grant;
  logic [IDX_W-1:0]        arb_idx, grant_idx;
  logic                    send, send_tail;

  rr_arbiter #(.N(NUM_INPUTS), .IW(IDX_W)) u_arb (
    .req   (bus.req_in),
    .base  (rr_ptr_q),
    .grant (arb_grant),
    .idx   (arb_idx)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      owner_q   <= '0;
      rr_ptr_q  <= '0;
      credits_q <= FULL;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      rr_ptr_q  <= rr_ptr_d;
      credits_q <= credits_d;
      err_q     <= err_d;
    end
  end

  // Grant and send. Everything is forced quiet while rst is high so a
  // packet interrupted by reset cannot push one more flit.
  always_comb begin
    owner_oh = '0;
    for (int j = 0; j < NUM_INPUTS; j++) begin
      owner_oh[j] = (IDX_W'(j) == owner_q);
    end
    grant     = '0;
    grant_idx = '0;
    if (!rst) begin
      if (state_q == LOCKED) begin
        grant     = owner_oh;
        grant_idx = owner_q;
      end else begin
        grant     = arb_grant;
        grant_idx = arb_idx;
      end
    end
    send      = (|(grant & bus.req_in)) && (credits_q != '0);
    send_tail = send && (|(grant & bus.is_tail_in));
  end

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    case (state_q)
      IDLE: begin
        // Single-flit packets never take the lock.
        if (send && !send_tail) begin
          state_d = LOCKED;
          owner_d = grant_idx;
        end
      end
      LOCKED: begin
        if (send_tail) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Priority only moves past an input once its packet has fully left,
    // so a head stalled on credits keeps its turn.
    if (send_tail) begin
      rr_ptr_d = (grant_idx == IDX_W'(NUM_INPUTS - 1)) ? '0 : grant_idx + IDX_W'(1);
    end

    credits_d = credits_q;
    err_d     = err_q;
    if (bus.credit_in && !send) begin
      if (credits_q == FULL) err_d = 1'b1;
      else                   credits_d = credits_q + CREDIT_WIDTH'(1);
    end else if (!bus.credit_in && send) begin
      credits_d = credits_q - CREDIT_WIDTH'(1);
    end
  end

  assign bus.grant_out      = grant;
  assign bus.send_out       = send;
  assign bus.locked_out     = (state_q == LOCKED);
  assign bus.credits_out    = credits_q;
  assign bus.credit_err_out = err_q;

endmodule

// File: doc/wormhole_output_allocator.md
Name: wormhole_output_allocator

Overview:
- Per-output-port switch allocator for the router.
- Arbitrates round-robin among input ports whose head flit targets this output. It holds the grant for the whole packet (wormhole) until the tail flit passes.
- Gates every transfer on a downstream credit counter, so the output never overruns the next hop's flit buffer.
- One instance per router output; it drives that output's crossbar select and the dequeue of the granted input FIFO.

Parameters:
- NUM_INPUTS, 2, number of requesting input ports (≥2).
- FLIT_BUFFER_DEPTH, 4, downstream buffer depth; the credit counter resets to this value.
- CREDIT_WIDTH, $clog2(FLIT_BUFFER_DEPTH+1), credit counter width (derived).

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- req_in  in  NUM_INPUTS  input i has a valid head flit routed to this output.
- is_tail_in  in  NUM_INPUTS  head flit of input i is a tail flit.
- credit_in  in  1  one-cycle pulse: downstream freed one buffer slot.
- grant_out  out  NUM_INPUTS  one-hot crossbar select; all zeros when nothing is granted.
- send_out  out  1  a flit transfers this cycle; drives the output send and the granted input's dequeue.
- locked_out  out  1  a packet currently owns the output.
- credits_out  out  CREDIT_WIDTH  current downstream credit count.
- credit_err_out  out  1  sticky error flag: credit overflow observed.

Behaviour:
- Reset (rst=1 at posedge):
  - state=IDLE, rr_ptr=0, credits=FLIT_BUFFER_DEPTH, credit_err_out=0.
  - grant_out=0, send_out=0, locked_out=0.
  - Reset mid-packet drops ownership immediately; no flit is sent in the reset cycle.
- State register: {IDLE, LOCKED}, plus owner index and rr_ptr.
- grant_out is combinational from state and request:
  - IDLE: grant_out selects the first asserted req_in starting at rr_ptr and wrapping modulo NUM_INPUTS. It is zero if no request is asserted.
  - LOCKED: grant_out = onehot(owner) regardless of req_in.
- send_out = |(grant_out & req_in) && credits != 0. The first flit of a packet therefore transfers in the same cycle it is granted (zero allocation latency).
- IDLE -> LOCKED:
  - Taken when send_out=1 and the sent flit is not a tail; owner := granted index.
  - A single-flit packet (head=tail) leaves state at IDLE.
- LOCKED -> IDLE: taken on send_out=1 with is_tail_in[owner]=1.
- LOCKED with req_in[owner]=0 (input bubble): hold the lock and send nothing; other requesters stay blocked.
- LOCKED with credits=0: hold the lock, send_out=0.
- rr_ptr update:
  - On every tail send, rr_ptr := (granted index + 1) mod NUM_INPUTS.
  - It is unchanged otherwise, so a blocked head keeps priority.
- Credits, next value = credits + credit_in − send_out:
  - Simultaneous credit_in and send leaves credits unchanged.
  - credit_in at credits=FLIT_BUFFER_DEPTH with no send: the count saturates and credit_err_out sets until reset.
  - Underflow is impossible because send requires credits≠0.
- locked_out = (state==LOCKED), registered.
- credits_out is the register value, not the next value.

Decomposition:
- Shared package noc_alloc_pkg holds:
  - the state enum alloc_state_t {IDLE, LOCKED};
  - the function onehot_to_idx;
  - the credit width computation.
- Sub-module rr_arbiter (parameter N): combinational priority pick from a base pointer, returning a one-hot grant plus the grant index. The allocator instantiates one.

Test Plan (NUM_INPUTS=2, FLIT_BUFFER_DEPTH=4, credit_in looped back from send_out one cycle later unless stated):
- Reset check:
  - Stimulus: rst held 3 cycles, then released with no requests.
  - Required: grant_out=00, send_out=0, locked_out=0, credits_out=4 throughout.
- Single-flit packets alternating:
  - Stimulus: req_in=11 with is_tail_in=11 held for 4 cycles.
  - Required: grant_out sequence 01,10,01,10; send_out=1 every cycle; locked_out stays 0.
- Wormhole hold:
  - Stimulus: input0 sends a 3-flit packet (tails 0,0,1) while input1 requests continuously.
  - Required: grant_out=01 for 3 cycles with locked_out=1 after the first flit; then grant_out=10 in cycle 4.
- Credit exhaustion:
  - Stimulus: credit_in tied 0, req_in=01, is_tail_in=1 for 6 cycles.
  - Required: exactly 4 send_out pulses, credits_out 4→0; send_out=0 afterwards.
  - Then 2 credit_in pulses: credits_out=2 and 2 further sends.
- Bubble and reset mid-packet:
  - Stimulus: input1 sends a non-tail head, then req_in=00 for 2 cycles.
  - Required: locked_out=1 and grant_out=10 held, send_out=0.
  - Then rst asserted: the next cycle shows locked_out=0, grant_out=00, credits_out=4.
- Credit overflow:
  - Stimulus: credit_in pulse at credits_out=4 with no send.
  - Required: credits_out stays 4, credit_err_out=1 and remains 1 until rst.
